// File: rtl/keycode_to_scancode_if.sv
// Keycode-in / scancode-out bus for keycode_to_scancode.
//   strobe_in  keycode valid pulse (master -> slave)
//   keycode    [7:0] key, [8] key-up, [15:9] don't care
//   tx_ready   downstream transmitter can accept a byte
//   strobe_out one-cycle pulse, code_out valid
//   code_out   AT set-2 scancode byte
//   busy       sequence in progress
//   err        one-cycle pulse: unmapped key or strobe_in while busy
interface keycode_to_scancode_if;
    localparam int unsigned KEYCODE_W = 16;
    localparam int unsigned BYTE_W    = 8;

    logic                 strobe_in;
    logic [KEYCODE_W-1:0] keycode;
    logic                 tx_ready;
    logic                 strobe_out;
    logic [BYTE_W-1:0]    code_out;
    logic                 busy;
    logic                 err;

    modport master (
        output strobe_in, keycode, tx_ready,
        input  strobe_out, code_out, busy, err
    );

    modport slave (
        input  strobe_in, keycode, tx_ready,
        output strobe_out, code_out, busy, err
    );
endinterface

// File: rtl/keycode_to_scancode.sv
// keycode_to_scancode: turns a lispm keycode into the AT set-2 scancode
// byte sequence (E0 / F0 prefixes as needed), one byte per strobe, paced by
// tx_ready and spaced by GAP_CYCLES idle cycles.
//   clk    system clock
//   reset  synchronous, active-low reset
//   bus    keycode_to_scancode_if.slave (strobe_in, keycode, tx_ready in;
//          strobe_out, code_out, busy, err out)

// Key -> {ext, sc} table; sc == 8'h00 marks an unmapped key.
module keycode_rom (
    input  logic [7:0] addr,
    output logic [8:0] data
);
    always_comb begin
        data = 9'h000;
        case (addr)
            8'h12:   data = {1'b0, 8'h5A};
            8'h20:   data = {1'b1, 8'h14};
            8'h30:   data = {1'b1, 8'h75};
            8'h31:   data = {1'b1, 8'h72};
            8'h45:   data = {1'b0, 8'h1C};
            8'h46:   data = {1'b0, 8'h32};
            default: data = 9'h000;
        endcase
    end
endmodule

module keycode_to_scancode #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    keycode_to_scancode_if.slave  bus
);
    localparam int unsigned CNT_W  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_E0,
        S_F0,
        S_CODE,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    state_t              follow_q, follow_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   key_q, key_d;
    logic                up_q, up_d;
    logic                ext_q, ext_d;
    logic [BYTE_W-1:0]   sc_q, sc_d;
    logic                looked_q, looked_d;
    logic                strobe_out_q, strobe_out_d;
    logic [BYTE_W-1:0]   code_out_q, code_out_d;
    logic                err_q, err_d;

    logic [8:0]          rom_data;
    logic                unused_keycode_hi;

    keycode_rom u_rom (
        .addr (key_q),
        .data (rom_data)
    );

    assign unused_keycode_hi = ^bus.keycode[15:9];

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        follow_d     = follow_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        up_d         = up_q;
        ext_d        = ext_q;
        sc_d         = sc_q;
        looked_d     = looked_q;
        strobe_out_d = 1'b0;
        code_out_d   = code_out_q;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.strobe_in) begin
                    key_d    = bus.keycode[7:0];
                    up_d     = bus.keycode[8];
                    looked_d = 1'b0;
                    state_d  = S_LOOKUP;
                end
            end

            // First cycle registers the ROM word, second cycle acts on it.
            S_LOOKUP: begin
                if (!looked_q) begin
                    ext_d    = rom_data[8];
                    sc_d     = rom_data[7:0];
                    looked_d = 1'b1;
                end else if (sc_q == 8'h00) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (ext_q) begin
                    state_d = S_E0;
                end else if (up_q) begin
                    state_d = S_F0;
                end else begin
                    state_d = S_CODE;
                end
            end

            S_E0, S_F0, S_CODE: begin
                if (bus.tx_ready) begin
                    strobe_out_d = 1'b1;
                    case (state_q)
                        S_E0: begin
                            code_out_d = 8'hE0;
                            follow_d   = up_q ? S_F0 : S_CODE;
                        end
                        S_F0: begin
                            code_out_d = 8'hF0;
                            follow_d   = S_CODE;
                        end
                        default: begin
                            code_out_d = sc_q;
                            follow_d   = S_IDLE;
                        end
                    endcase
                    if (GAP_CYCLES == 0) begin
                        state_d = follow_d;
                    end else begin
                        cnt_d   = CNT_W'(GAP_CYCLES);
                        state_d = S_GAP;
                    end
                end
            end

            // Leave on the cycle the counter would reach zero.
            S_GAP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = follow_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        // A keycode offered mid-sequence is dropped and flagged.
        if (state_q != S_IDLE && bus.strobe_in) begin
            err_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            follow_q     <= S_IDLE;
            cnt_q        <= '0;
            key_q        <= '0;
            up_q         <= 1'b0;
            ext_q        <= 1'b0;
            sc_q         <= '0;
            looked_q     <= 1'b0;
            strobe_out_q <= 1'b0;
            code_out_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            follow_q     <= follow_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            up_q         <= up_d;
            ext_q        <= ext_d;
            sc_q         <= sc_d;
            looked_q     <= looked_d;
            strobe_out_q <= strobe_out_d;
            code_out_q   <= code_out_d;
            err_q        <= err_d;
        end
    end

    assign bus.strobe_out = strobe_out_q;
    assign bus.code_out   = code_out_q;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_keycode_to_scancode.sv
module tb_keycode_to_scancode;
    localparam int GAP  = 2;
    localparam int MAXE = 160;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keycode_to_scancode_if bus ();

    keycode_to_scancode #(.GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Per-edge stimulus schedule (index = edge number, 1-based).
    logic        rst_a [MAXE];
    logic        stb_a [MAXE];
    logic [15:0] kc_a  [MAXE];
    logic        rdy_a [MAXE];

    // Values observed just after each edge.
    logic        o_stb  [MAXE];
    logic        o_err  [MAXE];
    logic        o_busy [MAXE];
    logic [7:0]  o_code [MAXE];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bench copy of the key table: {ext, sc}, sc == 0 means unmapped.
    function automatic logic [8:0] map_key(input logic [7:0] k);
        case (k)
            8'h12:   return {1'b0, 8'h5A};
            8'h20:   return {1'b1, 8'h14};
            8'h30:   return {1'b1, 8'h75};
            8'h31:   return {1'b1, 8'h72};
            8'h45:   return {1'b0, 8'h1C};
            8'h46:   return {1'b0, 8'h32};
            default: return 9'h000;
        endcase
    endfunction

    task automatic clear_sched();
        for (int e = 0; e < MAXE; e++) begin
            rst_a[e] = 1'b1;
            stb_a[e] = 1'b0;
            kc_a[e]  = 16'h0000;
            rdy_a[e] = 1'b1;
        end
        rst_a[1] = 1'b0;
    endtask

    // Drive the schedule, then replay it through the reference model.
    task automatic run_scn(input int id, input int n);
        int          idle_from;
        int          err_at;
        int          next_early;
        logic [7:0]  q[$];
        logic [7:0]  code;
        logic        exp_stb, exp_err, exp_busy;
        logic [8:0]  m;

        for (int e = 1; e < n; e++) begin
            reset         = rst_a[e];
            bus.strobe_in = stb_a[e];
            bus.keycode   = kc_a[e];
            bus.tx_ready  = rdy_a[e];
            @(posedge clk);
            #1;
            o_stb[e]  = bus.strobe_out;
            o_err[e]  = bus.err;
            o_busy[e] = bus.busy;
            o_code[e] = bus.code_out;
        end
        bus.strobe_in = 1'b0;

        idle_from  = 0;
        err_at     = -1;
        next_early = 0;
        code       = 8'h00;
        q.delete();
        for (int e = 1; e < n; e++) begin
            exp_stb = 1'b0;
            exp_err = 1'b0;
            if (!rst_a[e]) begin
                q.delete();
                idle_from = e;
                err_at    = -1;
                code      = 8'h00;
            end else begin
                if (stb_a[e]) begin
                    if (e > idle_from) begin
                        m = map_key(kc_a[e][7:0]);
                        if (m[7:0] == 8'h00) begin
                            err_at    = e + 2;
                            idle_from = e + 2;
                        end else begin
                            if (m[8])       q.push_back(8'hE0);
                            if (kc_a[e][8]) q.push_back(8'hF0);
                            q.push_back(m[7:0]);
                            next_early = e + 3;
                            idle_from  = 1 << 30;
                        end
                    end else begin
                        exp_err = 1'b1;
                    end
                end
                if (err_at == e) exp_err = 1'b1;
                if (q.size() > 0 && e >= next_early && rdy_a[e]) begin
                    code       = q.pop_front();
                    exp_stb    = 1'b1;
                    next_early = e + GAP + 1;
                    if (q.size() == 0) idle_from = e + GAP;
                end
            end
            exp_busy = (e < idle_from);
            check_eq($sformatf("s%0d/e%0d/strobe_out", id, e), 32'(o_stb[e]), 32'(exp_stb));
            check_eq($sformatf("s%0d/e%0d/code_out", id, e), 32'(o_code[e]), 32'(code));
            check_eq($sformatf("s%0d/e%0d/err", id, e), 32'(o_err[e]), 32'(exp_err));
            check_eq($sformatf("s%0d/e%0d/busy", id, e), 32'(o_busy[e]), 32'(exp_busy));
        end
    endtask

    initial begin
        logic [7:0] pool [8];
        pool[0] = 8'h45; pool[1] = 8'h30; pool[2] = 8'h46; pool[3] = 8'h31;
        pool[4] = 8'h12; pool[5] = 8'h20; pool[6] = 8'h99; pool[7] = 8'h77;

        reset         = 1'b0;
        bus.strobe_in = 1'b0;
        bus.keycode   = 16'h0000;
        bus.tx_ready  = 1'b1;

        // Plain make: single byte three edges after acceptance.
        clear_sched();
        stb_a[3] = 1'b1; kc_a[3] = 16'h0045;
        run_scn(1, 20);
        check_eq("s1/first_strobe_edge", 32'(o_stb[6]), 32'd1);
        check_eq("s1/first_code", 32'(o_code[6]), 32'h1C);

        // Break: F0 then 1C.
        clear_sched();
        stb_a[3] = 1'b1; kc_a[3] = 16'h0145;
        run_scn(2, 20);

        // Extended break with a 10-cycle stall before F0.
        clear_sched();
        stb_a[3] = 1'b1; kc_a[3] = 16'h0130;
        for (int e = 9; e < 19; e++) rdy_a[e] = 1'b0;
        run_scn(3, 40);
        check_eq("s3/f0_after_stall", 32'(o_code[19]), 32'hF0);

        // Unmapped key.
        clear_sched();
        stb_a[3] = 1'b1; kc_a[3] = 16'h0099;
        run_scn(4, 16);

        // Second keycode while busy is rejected.
        clear_sched();
        stb_a[3] = 1'b1; kc_a[3] = 16'h0030;
        stb_a[4] = 1'b1; kc_a[4] = 16'h0045;
        run_scn(5, 24);

        // Reset in the gap after E0, then a fresh make.
        clear_sched();
        stb_a[3]  = 1'b1; kc_a[3]  = 16'h0130;
        rst_a[7]  = 1'b0;
        stb_a[12] = 1'b1; kc_a[12] = 16'h0045;
        run_scn(6, 30);

        // Random traffic.
        for (int s = 0; s < 25; s++) begin
            clear_sched();
            for (int e = 2; e < MAXE; e++) begin
                rdy_a[e] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 79) == 0) rst_a[e] = 1'b0;
                if (e < MAXE - 40 && $urandom_range(0, 4) == 0) begin
                    stb_a[e] = 1'b1;
                    kc_a[e]  = {7'($urandom), 1'($urandom), pool[$urandom_range(0, 7)]};
                end
            end
            run_scn(100 + s, MAXE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
